// File: rtl/ifw_ctrl_fsm.sv
// Input-feature write controller: pops ifw FIFO words, drives stage-0/1 write enables and
// sequences IDLE->DLOD->WABF->RST per tile. Optional stall counter under IFW_STALL_CNT_EN.
module ifw_ctrl_fsm #(
    parameter int ROW_WIDTH  = 8,
    parameter int TILE_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_WIDTH-1:0]  cfg_row_num,
    input  logic [TILE_WIDTH-1:0] cfg_tile_num,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic                  wr_stg0_last,
    input  logic                  wr_stg1_last,
    input  logic [2:0]            wr_curr_state,
    output logic                  wr_stg0_en,
    output logic                  wr_stg1_en,
    output logic [2:0]            ifw_curr_state,
    output logic                  idle2start,
    output logic                  row_last,
    output logic [2:0]            cfg_mast_state,
    output logic                  cnt_clr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           dbg_stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DLOD = 3'd1,
        S_WABF = 3'd2,
        S_RST  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [2:0] MAST_LEFT   = 3'd1;
    localparam logic [2:0] MAST_NORMAL = 3'd2;
    localparam logic [2:0] MAST_RIGH   = 3'd3;

    state_e                state_q, state_d;
    logic [ROW_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [ROW_WIDTH-1:0]  rows_q, rows_d;
    logic [TILE_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
    logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
    logic                  row_last_q, row_last_d;
    logic                  i2s_q, i2s_d;
    logic [2:0]            mast_q, mast_d;
    logic                  start_acc;
    logic                  row_done;

    assign wr_stg0_en     = (state_q == S_DLOD) && !fifo_empty;
    assign wr_stg1_en     = wr_stg0_en & wr_stg0_last;
    assign row_done       = wr_stg1_en & wr_stg1_last;
    assign fifo_rd        = wr_stg0_en;
    assign ifw_curr_state = state_q;
    assign idle2start     = i2s_q;
    assign row_last       = row_last_q;
    assign cfg_mast_state = mast_q;
    assign busy           = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        tile_cnt_d = tile_cnt_q;
        rows_d     = rows_q;
        tiles_d    = tiles_q;
        cnt_clr    = 1'b0;
        done       = 1'b0;
        start_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    rows_d     = (cfg_row_num == '0) ? ROW_WIDTH'(1) : cfg_row_num;
                    tiles_d    = (cfg_tile_num == '0) ? TILE_WIDTH'(1) : cfg_tile_num;
                    row_cnt_d  = '0;
                    tile_cnt_d = '0;
                    state_d    = S_DLOD;
                end
            end
            S_DLOD: begin
                if (row_done) begin
                    if (row_last_q) state_d = S_WABF;
                    else            row_cnt_d = row_cnt_q + ROW_WIDTH'(1);
                end
            end
            S_WABF: begin
                if (wr_curr_state == 3'd0) state_d = S_RST;
            end
            S_RST: begin
                cnt_clr   = 1'b1;
                row_cnt_d = '0;
                if (tile_cnt_q == tiles_q - TILE_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    tile_cnt_d = tile_cnt_q + TILE_WIDTH'(1);
                    state_d    = S_DLOD;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                tile_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from next-state values so these track the counters with no lag.
        row_last_d = (row_cnt_d == rows_d - ROW_WIDTH'(1));
        mast_d = mast_q;
        if (state_q != S_IDLE || start_acc) begin
            if (tiles_d == TILE_WIDTH'(1))                   mast_d = MAST_NORMAL;
            else if (tile_cnt_d == '0)                       mast_d = MAST_LEFT;
            else if (tile_cnt_d == tiles_d - TILE_WIDTH'(1)) mast_d = MAST_RIGH;
            else                                             mast_d = MAST_NORMAL;
        end
        i2s_d = (state_d == S_DLOD) && (state_q != S_DLOD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            rows_q     <= '0;
            tile_cnt_q <= '0;
            tiles_q    <= '0;
            row_last_q <= 1'b0;
            i2s_q      <= 1'b0;
            mast_q     <= MAST_NORMAL;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            rows_q     <= rows_d;
            tile_cnt_q <= tile_cnt_d;
            tiles_q    <= tiles_d;
            row_last_q <= row_last_d;
            i2s_q      <= i2s_d;
            mast_q     <= mast_d;
        end
    end

`ifdef IFW_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (state_q == S_DLOD && fifo_empty && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign dbg_stall_cnt = stall_q;
`else
    assign dbg_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ifw_ctrl_fsm.sv
// Bench for ifw_ctrl_fsm: job table plus random jobs checked cycle by cycle against a
// job-level reference model, with hand sequences for WABF hold and mid-job reset.
module tb_ifw_ctrl_fsm;
    localparam int RW = 8;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [RW-1:0] cfg_row_num;
    logic [TW-1:0] cfg_tile_num;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          wr_stg0_last;
    logic          wr_stg1_last;
    logic [2:0]    wr_curr_state;
    logic          wr_stg0_en;
    logic          wr_stg1_en;
    logic [2:0]    ifw_curr_state;
    logic          idle2start;
    logic          row_last;
    logic [2:0]    cfg_mast_state;
    logic          cnt_clr;
    logic          busy;
    logic          done;
    logic [15:0]   dbg_stall_cnt;

    ifw_ctrl_fsm #(.ROW_WIDTH(RW), .TILE_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_row_num(cfg_row_num), .cfg_tile_num(cfg_tile_num),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .wr_stg0_last(wr_stg0_last), .wr_stg1_last(wr_stg1_last),
        .wr_curr_state(wr_curr_state),
        .wr_stg0_en(wr_stg0_en), .wr_stg1_en(wr_stg1_en),
        .ifw_curr_state(ifw_curr_state), .idle2start(idle2start),
        .row_last(row_last), .cfg_mast_state(cfg_mast_state),
        .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .dbg_stall_cnt(dbg_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected mast value for each tile, consumed at every idle2start pulse.
    logic [2:0] exp_q[$];

    // Reference model: job phase (0 idle,1 load,2 wait,3 clear,4 done), position and config.
    int         m_p, m_row, m_tile, m_rows, m_tiles, m_stall;
    bit         m_first;
    logic [2:0] m_mast;

    // Downstream counter emulation and stimulus knobs.
    int s0_len, s1_len, ds0, ds1, empty_mode, empty_pct, hold, wabf_cnt;
    bit tog;
    int n_i2s, n_clr, n_done, n_pop;
    bit seen_done;

    typedef struct {
        int rows;
        int tiles;
        int s0;
        int s1;
        int mode;
        int pct;
        int hold;
        int exp_pops;
        int exp_pulses;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] mast_of(input int t, input int tiles);
        if (tiles == 1)         return 3'd2;
        if (t == 0)             return 3'd1;
        if (t == tiles - 1)     return 3'd3;
        return 3'd2;
    endfunction

    task automatic model_reset();
        m_p = 0; m_row = 0; m_tile = 0; m_rows = 0; m_tiles = 0; m_stall = 0;
        m_first = 0; m_mast = 3'd2; wabf_cnt = 0;
        exp_q.delete();
    endtask

    task automatic observe();
        logic [31:0] act, exp;
        logic        e_wr0, e_rl;
        logic [15:0] e_st;
        e_wr0 = (m_p == 1) && !fifo_empty;
        e_rl  = (m_p == 1) && (m_row == m_rows - 1);
`ifdef IFW_STALL_CNT_EN
        e_st = 16'(m_stall);
`else
        e_st = 16'd0;
`endif
        act = {1'b0, ifw_curr_state, wr_stg0_en, wr_stg1_en, fifo_rd, idle2start,
               row_last & (m_p == 1), cfg_mast_state, cnt_clr, busy, done, dbg_stall_cnt};
        exp = {1'b0, 3'(m_p), e_wr0, e_wr0 & wr_stg0_last, e_wr0, m_first,
               e_rl, m_mast, (m_p == 3), (m_p != 0), (m_p == 4), e_st};
        check("cycle_outputs", act, exp);
        if (idle2start === 1'b1) begin
            n_i2s++;
            if (exp_q.size() == 0) check("mast_queue_underflow", 32'd1, 32'd0);
            else                   check("mast_at_tile_start", 32'(cfg_mast_state), 32'(exp_q.pop_front()));
        end
        if (cnt_clr === 1'b1) n_clr++;
        if (fifo_rd === 1'b1) n_pop++;
        if (done === 1'b1) begin
            n_done++;
            seen_done = 1'b1;
        end
    endtask

    task automatic advance();
        bit e_wr0, rdone;
        e_wr0 = (m_p == 1) && !fifo_empty;
        rdone = e_wr0 && wr_stg0_last && wr_stg1_last;
        if (e_wr0) begin
            if (ds0 == s0_len - 1) begin
                ds0 = 0;
                ds1 = (ds1 == s1_len - 1) ? 0 : ds1 + 1;
            end else begin
                ds0++;
            end
        end
        if (m_p == 1 && fifo_empty && m_stall < 65535) m_stall++;
        if (m_p == 2) wabf_cnt++;
        m_first = 0;
        case (m_p)
            0: if (start) begin
                m_rows  = (cfg_row_num == 0) ? 1 : int'(cfg_row_num);
                m_tiles = (cfg_tile_num == 0) ? 1 : int'(cfg_tile_num);
                m_row = 0; m_tile = 0; m_stall = 0; ds0 = 0; ds1 = 0; wabf_cnt = 0;
                m_mast = mast_of(0, m_tiles);
                for (int t = 0; t < m_tiles; t++) exp_q.push_back(mast_of(t, m_tiles));
                m_p = 1; m_first = 1;
            end
            1: if (rdone) begin
                if (m_row == m_rows - 1) m_p = 2;
                else                     m_row++;
            end
            2: if (wr_curr_state == 3'd0) m_p = 3;
            3: begin
                m_row = 0; wabf_cnt = 0;
                if (m_tile == m_tiles - 1) begin
                    m_p = 4;
                end else begin
                    m_tile++;
                    m_mast = mast_of(m_tile, m_tiles);
                    m_p = 1; m_first = 1;
                end
            end
            4: begin
                m_tile = 0; m_mast = mast_of(0, m_tiles); m_p = 0;
            end
            default: m_p = 0;
        endcase
    endtask

    task automatic step(input bit st);
        @(negedge clk);
        start        = st;
        wr_stg0_last = (ds0 == s0_len - 1);
        wr_stg1_last = (ds1 == s1_len - 1);
        case (empty_mode)
            0:       fifo_empty = 1'b0;
            1: begin fifo_empty = tog; tog = ~tog; end
            default: fifo_empty = ($urandom_range(0, 99) < empty_pct);
        endcase
        wr_curr_state = (wabf_cnt < hold) ? 3'd1 : 3'd0;
        #1;
        observe();
        advance();
    endtask

    task automatic setup_job(input vec_t v);
        s0_len = v.s0; s1_len = v.s1; empty_mode = v.mode; empty_pct = v.pct; hold = v.hold;
        cfg_row_num = RW'(v.rows); cfg_tile_num = TW'(v.tiles);
        n_i2s = 0; n_clr = 0; n_done = 0; n_pop = 0; seen_done = 0; tog = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        setup_job(v);
        step(1'b1);
        for (int c = 0; c < 5000 && !seen_done; c++) step(1'b0);
        if (!seen_done) check("job_timeout", 32'd1, 32'd0);
        step(1'b0);
        check("pops", 32'(n_pop), 32'(v.exp_pops));
        check("idle2start_pulses", 32'(n_i2s), 32'(v.exp_pulses));
        check("cnt_clr_pulses", 32'(n_clr), 32'(v.exp_pulses));
        check("done_pulses", 32'(n_done), 32'd1);
        check("mast_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{rows: 2, tiles: 1, s0: 4, s1: 2, mode: 0, pct: 0,  hold: 0,  exp_pops: 16, exp_pulses: 1};
        tbl[1] = '{rows: 1, tiles: 3, s0: 2, s1: 1, mode: 0, pct: 0,  hold: 1,  exp_pops: 6,  exp_pulses: 3};
        tbl[2] = '{rows: 2, tiles: 2, s0: 3, s1: 2, mode: 1, pct: 0,  hold: 2,  exp_pops: 24, exp_pulses: 2};
        tbl[3] = '{rows: 1, tiles: 1, s0: 2, s1: 2, mode: 0, pct: 0,  hold: 10, exp_pops: 4,  exp_pulses: 1};
        tbl[4] = '{rows: 0, tiles: 0, s0: 3, s1: 1, mode: 2, pct: 30, hold: 3,  exp_pops: 3,  exp_pulses: 1};
        tbl[5] = '{rows: 3, tiles: 4, s0: 1, s1: 2, mode: 2, pct: 50, hold: 0,  exp_pops: 24, exp_pulses: 4};

        reset = 1'b0; start = 1'b0; cfg_row_num = '0; cfg_tile_num = '0;
        fifo_empty = 1'b0; wr_stg0_last = 1'b0; wr_stg1_last = 1'b0; wr_curr_state = 3'd0;
        s0_len = 1; s1_len = 1; ds0 = 0; ds1 = 0; empty_mode = 0; empty_pct = 0; hold = 0; tog = 0;
        n_i2s = 0; n_clr = 0; n_done = 0; n_pop = 0; seen_done = 0;
        model_reset();

        // Reset state while held, then idle with start low.
        repeat (2) @(negedge clk);
        #1;
        observe();
        reset = 1'b1;
        repeat (3) step(1'b0);

        foreach (tbl[i]) run_job(tbl[i]);

        // Abort mid-load at row 1 of tile 1; a start while busy must be ignored.
        v = '{rows: 2, tiles: 2, s0: 2, s1: 1, mode: 0, pct: 0, hold: 0, exp_pops: 0, exp_pulses: 0};
        setup_job(v);
        step(1'b1);
        for (int c = 0; c < 200 && !(m_p == 1 && m_tile == 1 && m_row == 1); c++)
            step(c == 2);
        check("reached_abort_point", 32'(m_p == 1 && m_tile == 1 && m_row == 1), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        observe();
        repeat (2) step(1'b0);
        reset = 1'b1;
        repeat (3) step(1'b0);
        check("abort_no_done", 32'(n_done), 32'd0);

        // Random jobs, expected totals from plain arithmetic on the job shape.
        for (int j = 0; j < 8; j++) begin
            v.rows  = $urandom_range(1, 3);
            v.tiles = $urandom_range(1, 4);
            v.s0    = $urandom_range(1, 3);
            v.s1    = $urandom_range(1, 3);
            v.mode  = $urandom_range(0, 2);
            v.pct   = $urandom_range(0, 70);
            v.hold  = $urandom_range(0, 5);
            v.exp_pops   = v.rows * v.tiles * v.s0 * v.s1;
            v.exp_pulses = v.tiles;
            run_job(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
